monitor_dmem_data_in: RTL and testbench
=======================================

Name: monitor_dmem_data_in

Overview:
- Avalon-MM slave input port: the read-back counterpart of the monitor's output-port registers.
- Samples a 32-bit data word from the tinymips data-memory read bus (in_port) through a 2-flop synchronizer and presents it to the monitor CPU.
- Records per-bit edges in an edge-capture register and raises a maskable interrupt, so the monitor can detect changes on the dmem read bus without polling.

Parameters:
- WIDTH, 32, width of in_port and of the data path (1..32); readdata bits at and above WIDTH read 0.
- EDGE_TYPE, 0, edge detected per bit: 0 = rising, 1 = falling, 2 = any.
- RESET_VALUE, 0, reset value of the interrupt-mask register.

Ports:
- clk  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  2  register select: 0 data, 1 direction, 2 irqmask, 3 edgecapture.
- chipselect  in  1  Avalon slave select.
- read  in  1  read strobe, qualified by chipselect.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous input word (dmem read data).
- irq  out  1  level interrupt.

Behaviour:
- Reset (asynchronous, reset=1): sync0, sync1, prev, edgecapture, readdata and irq = 0; irqmask = RESET_VALUE; prime counter = 0.
- Synchronizer: sync0 <= in_port; sync1 <= sync0. prev <= sync1 every cycle.
- Prime counter:
  - 2-bit counter increments each cycle after reset release and saturates at 3.
  - Edge detection is suppressed while the counter is below 3, so no spurious edges are recorded from the reset-to-zero chain.
- Edge detect per bit i:
  - rising: sync1[i] & ~prev[i].
  - falling: ~sync1[i] & prev[i].
  - any: sync1[i] ^ prev[i].
- Input latency: a change on in_port is visible at register 0 and sets edgecapture 3 cycles later (sync0, sync1, then the edgecapture flop).
- Edgecapture: sticky per bit once set.
  - Write to address 3: write-1-to-clear. Bit i clears where writedata[i] = 1; bits with writedata[i] = 0 are unchanged.
  - A set and a clear on the same bit in the same cycle: set wins, bit ends at 1.
- Irqmask (address 2): read/write. It loads writedata[WIDTH-1:0] when chipselect & ~write_n.
- Address 1 (direction): reads 0, writes ignored. Address 0: writes ignored.
- irq: registered, irq <= |(edgecapture & irqmask), computed from the current register values.
  - 1-cycle latency after an edgecapture set or a mask change.
  - Deasserts one cycle after the clearing write lands.
- Read timing:
  - readdata <= {zero-extend, mux(address)} when chipselect & read; otherwise it holds its value.
  - Read latency is fixed at 1; there are no wait states.
  - Register 0 returns sync1.
- Simultaneous read and write of the same address in one cycle: readdata returns the pre-write value.
- Reset asserted mid-operation: all state clears immediately, irq drops asynchronously, and the prime counter restarts.
- Unused writedata bits (at and above WIDTH) are ignored.

Decomposition:
- Shared package monitor_pio_pkg holds:
  - register address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3;
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings.
- One natural sub-module: monitor_pio_edge_detect.
  - Contains the synchronizer, prev register, prime counter and per-bit edge function.
  - Parameterized by WIDTH and EDGE_TYPE; output is a WIDTH-bit edge pulse vector.
- The top level keeps the register file, the readdata mux and irq.

Test Plan:
- Reset release, in_port=32'hFFFF_FFFF held throughout -> edgecapture reads 0 and irq stays 0 (prime suppression); the read of address 0 in the following cycle returns 32'hFFFF_FFFF.
- EDGE_TYPE=0, in_port 0 -> 32'h0000_0005, irqmask=32'h4 -> edgecapture=32'h5 three cycles after the change; irq=1 one cycle later. Writing 32'h4 to address 3 -> edgecapture=32'h1 and irq=0.
- EDGE_TYPE=2, toggle bit 7 twice; write 32'h80 to address 3 in the same cycle a new edge on bit 7 lands -> bit 7 remains 1 (set wins).
- Read address 1 and address 0 while writing 32'hDEAD_BEEF to address 0 -> address 1 returns 0; address 0 data is unchanged; readdata is valid exactly 1 cycle after the read strobe.
- WIDTH=8, in_port=8'hA5 -> address 0 reads 32'h0000_00A5. Writing 32'hFFFF_FFFF to address 2 -> irqmask reads 32'h0000_00FF.
- Assert reset while irq=1 and edgecapture=32'h3 -> irq=0 asynchronously; all registers read 0 (irqmask reads RESET_VALUE) after release; no edge is recorded during the 3 priming cycles.

Source files
------------

// File: rtl/monitor_pio_pkg.sv
// ----------------------------------------------------------------------------
// monitor_pio_pkg
// Shared definitions for the monitor's Avalon-MM PIO ports: register map,
// edge-type encodings, the decoded bus request payload and the per-bit
// edge rule.
// ----------------------------------------------------------------------------
package monitor_pio_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 2;
   localparam int unsigned PRIME_W = 2;

   // Register map
   localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_DIR     = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

   // Edge-type encodings
   localparam int unsigned EDGE_RISING  = 0;
   localparam int unsigned EDGE_FALLING = 1;
   localparam int unsigned EDGE_ANY     = 2;

   // Prime counter value at which edge detection is enabled
   localparam logic [PRIME_W-1:0] PRIME_DONE = 2'd3;

   // Decoded slave request for one cycle
   typedef struct packed {
      logic              rd;
      logic              wr;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } avmm_req_t;

   // Per-bit edge rule: cur is the synchronized value, old the previous one
   function automatic logic edge_bit(input int unsigned edge_type,
                                     input logic        cur,
                                     input logic        old);
      logic hit;
      hit = 1'b0;
      case (edge_type)
         EDGE_RISING:  hit = cur & ~old;
         EDGE_FALLING: hit = ~cur & old;
         default:      hit = cur ^ old;
      endcase
      return hit;
   endfunction

endpackage : monitor_pio_pkg

// File: rtl/monitor_pio_edge_detect.sv
// ----------------------------------------------------------------------------
// monitor_pio_edge_detect
// Two-flop synchronizer for an asynchronous input word, a one-cycle history
// register and a per-bit edge detector. A small prime counter keeps the
// detector quiet for the first three cycles after reset so that the
// reset-to-zero chain cannot produce spurious edges.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   i_data    in   asynchronous input word
//   o_sync    out  synchronized input word (registered)
//   o_edge_c  out  per-bit edge pulses (combinational from registers)
// ----------------------------------------------------------------------------
module monitor_pio_edge_detect
   import monitor_pio_pkg::*;
#(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned EDGE_TYPE = EDGE_RISING
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_sync,
   output logic [WIDTH-1:0] o_edge_c
);

   logic [WIDTH-1:0]   r_sync0;
   logic [WIDTH-1:0]   r_sync1;
   logic [WIDTH-1:0]   r_prev;
   logic [PRIME_W-1:0] r_prime;
   logic [WIDTH-1:0]   w_edge;
   logic               w_primed;

   // Synchronizer chain and history register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync0 <= '0;
         r_sync1 <= '0;
         r_prev  <= '0;
      end else begin
         r_sync0 <= i_data;
         r_sync1 <= r_sync0;
         r_prev  <= r_sync1;
      end
   end

   // Saturating prime counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prime <= '0;
      end else if (r_prime != PRIME_DONE) begin
         r_prime <= r_prime + PRIME_W'(1);
      end
   end

   assign w_primed = (r_prime == PRIME_DONE);

   // Per-bit edge function
   always_comb begin
      w_edge = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         w_edge[i] = edge_bit(EDGE_TYPE, r_sync1[i], r_prev[i]);
      end
   end

   assign o_edge_c = w_primed ? w_edge : '0;
   assign o_sync   = r_sync1;

endmodule : monitor_pio_edge_detect

// File: rtl/monitor_dmem_data_in.sv
// ----------------------------------------------------------------------------
// monitor_dmem_data_in
// Avalon-MM slave input port that lets the monitor CPU read back the
// tinymips data-memory read bus. The bus word is synchronized, per-bit
// edges are latched in a sticky write-1-to-clear edgecapture register and
// a maskable level interrupt is raised while any unmasked capture bit is set.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous active-high reset
//   address     in   register select (0 data, 1 direction, 2 irqmask,
//                    3 edgecapture)
//   chipselect  in   slave select
//   read        in   read strobe, qualified by chipselect
//   write_n     in   active-low write strobe, qualified by chipselect
//   writedata   in   write data
//   readdata    out  registered read data, one cycle after the strobe
//   in_port     in   asynchronous input word
//   irq         out  registered level interrupt
// ----------------------------------------------------------------------------
module monitor_dmem_data_in
   import monitor_pio_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned EDGE_TYPE   = EDGE_RISING,
   parameter logic [31:0] RESET_VALUE = 32'h0000_0000
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   avmm_req_t         w_req;
   logic [WIDTH-1:0]  w_sync;
   logic [WIDTH-1:0]  w_edge;
   logic [WIDTH-1:0]  w_wdata;
   logic [WIDTH-1:0]  w_clr;
   logic              w_wr_mask;
   logic              w_wr_edgecap;
   logic [DATA_W-1:0] w_rd_mux;
   logic              w_unused_wdata;

   logic [WIDTH-1:0]  r_edgecap;
   logic [WIDTH-1:0]  r_irqmask;
   logic [DATA_W-1:0] r_readdata;
   logic              r_irq;

   // Synchronizer and edge detector
   monitor_pio_edge_detect #(
      .WIDTH     (WIDTH),
      .EDGE_TYPE (EDGE_TYPE)
   ) u_edge_detect (
      .clk      (clk),
      .reset    (reset),
      .i_data   (in_port),
      .o_sync   (w_sync),
      .o_edge_c (w_edge)
   );

   // Bus request decode
   assign w_req.rd    = chipselect & read;
   assign w_req.wr    = chipselect & ~write_n;
   assign w_req.addr  = address;
   assign w_req.wdata = writedata;

   assign w_wdata      = w_req.wdata[WIDTH-1:0];
   assign w_wr_mask    = w_req.wr && (w_req.addr == ADDR_IRQMASK);
   assign w_wr_edgecap = w_req.wr && (w_req.addr == ADDR_EDGECAP);
   assign w_clr        = w_wr_edgecap ? w_wdata : '0;

   // Bits of writedata above WIDTH have no destination
   assign w_unused_wdata = ^w_req.wdata;

   // Sticky edge capture; a new edge overrides a same-cycle clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_edgecap <= '0;
      end else begin
         r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      end
   end

   // Interrupt mask register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irqmask <= WIDTH'(RESET_VALUE);
      end else if (w_wr_mask) begin
         r_irqmask <= w_wdata;
      end
   end

   // Level interrupt from current capture and mask
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= |(r_edgecap & r_irqmask);
      end
   end

   // Read mux; direction register is input-only and reads zero
   always_comb begin
      w_rd_mux = '0;
      case (w_req.addr)
         ADDR_DATA:    w_rd_mux = DATA_W'(w_sync);
         ADDR_DIR:     w_rd_mux = '0;
         ADDR_IRQMASK: w_rd_mux = DATA_W'(r_irqmask);
         ADDR_EDGECAP: w_rd_mux = DATA_W'(r_edgecap);
         default:      w_rd_mux = '0;
      endcase
   end

   // Read data register; samples pre-write register values
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_readdata <= '0;
      end else if (w_req.rd) begin
         r_readdata <= w_rd_mux;
      end
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule : monitor_dmem_data_in

// File: tb/tb_monitor_dmem_data_in.sv
module tb_monitor_dmem_data_in;

   localparam int NI   = 3;
   localparam int HMAX = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        read;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] pin   [NI];
   logic [31:0] rdata [NI];
   logic        irq_o [NI];

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic [31:0] m_rd   [NI];
   logic [31:0] m_ec   [NI];
   logic [31:0] m_mask [NI];
   logic        m_irq  [NI];
   logic [31:0] hist   [NI][HMAX];
   int          n;

   always #5 clk = ~clk;

   monitor_dmem_data_in #(.WIDTH(32), .EDGE_TYPE(0), .RESET_VALUE(32'h0000_0000)) u_rise (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read(read), .write_n(write_n), .writedata(writedata),
      .readdata(rdata[0]), .in_port(pin[0]), .irq(irq_o[0]));

   monitor_dmem_data_in #(.WIDTH(32), .EDGE_TYPE(2), .RESET_VALUE(32'h0000_00F0)) u_any (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read(read), .write_n(write_n), .writedata(writedata),
      .readdata(rdata[1]), .in_port(pin[1]), .irq(irq_o[1]));

   monitor_dmem_data_in #(.WIDTH(8), .EDGE_TYPE(1), .RESET_VALUE(32'h0000_003C)) u_fall (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .read(read), .write_n(write_n), .writedata(writedata),
      .readdata(rdata[2]), .in_port(pin[2][7:0]), .irq(irq_o[2]));

   function automatic int p_width(input int k);
      return (k == 2) ? 8 : 32;
   endfunction

   function automatic int p_edge(input int k);
      case (k)
         0:       return 0;
         1:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic logic [31:0] p_rv(input int k);
      case (k)
         0:       return 32'h0000_0000;
         1:       return 32'h0000_00F0;
         default: return 32'h0000_003C;
      endcase
   endfunction

   function automatic logic [31:0] wmask(input int w);
      if (w >= 32) return 32'hFFFF_FFFF;
      return (32'h1 << w) - 32'h1;
   endfunction

   // Edge set between two successive synchronized samples
   function automatic logic [31:0] edges(input int e, input logic [31:0] cur, input logic [31:0] old);
      case (e)
         0:       return cur & ~old;
         1:       return ~cur & old;
         default: return cur ^ old;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         m_rd[k]   = '0;
         m_ec[k]   = '0;
         m_irq[k]  = 1'b0;
         m_mask[k] = p_rv(k) & wmask(p_width(k));
      end
      n = 0;
   endtask

   // Advance the model by one clock edge using the inputs now applied.
   // Cycle n after reset release sees in_port from cycle n-2 on the data
   // register, and records edges between cycles n-3 and n-2 once n >= 3.
   task automatic model_step();
      logic [31:0] m, data_v, ed, clr;
      for (int k = 0; k < NI; k++) begin
         m = wmask(p_width(k));
         hist[k][n] = pin[k] & m;
         data_v = (n >= 2) ? hist[k][n-2] : 32'h0;
         ed     = (n >= 3) ? (edges(p_edge(k), hist[k][n-2], hist[k][n-3]) & m) : 32'h0;
         if (chipselect && read) begin
            case (address)
               2'd0: m_rd[k] = data_v;
               2'd1: m_rd[k] = 32'h0;
               2'd2: m_rd[k] = m_mask[k];
               default: m_rd[k] = m_ec[k];
            endcase
         end
         m_irq[k] = |(m_ec[k] & m_mask[k]);
         clr = (chipselect && !write_n && address == 2'd3) ? (writedata & m) : 32'h0;
         if (chipselect && !write_n && address == 2'd2) m_mask[k] = writedata & m;
         m_ec[k] = (m_ec[k] & ~clr) | ed;
      end
      if (n < HMAX - 1) n++;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("model_rdata%0d", k), rdata[k], m_rd[k]);
         check($sformatf("model_irq%0d", k), 32'(irq_o[k]), 32'(m_irq[k]));
      end
   endtask

   task automatic bus_idle();
      chipselect = 1'b0; read = 1'b0; write_n = 1'b1; address = 2'd0; writedata = 32'h0;
   endtask

   task automatic idle(input int c);
      bus_idle();
      repeat (c) step();
   endtask

   task automatic rd_reg(input logic [1:0] a);
      chipselect = 1'b1; read = 1'b1; write_n = 1'b1; address = a; writedata = 32'h0;
      step();
      bus_idle();
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
      chipselect = 1'b1; read = 1'b0; write_n = 1'b0; address = a; writedata = d;
      step();
      bus_idle();
   endtask

   // Mid-cycle asynchronous reset pulse, outputs checked before any edge
   task automatic async_reset(input string tag);
      #3;
      reset = 1'b1;
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("%s_irq%0d", tag, k), 32'(irq_o[k]), 32'h0);
         check($sformatf("%s_rdata%0d", tag, k), rdata[k], 32'h0);
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      bus_idle();
      for (int k = 0; k < NI; k++) pin[k] = 32'hFFFF_FFFF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) begin
         check($sformatf("reset_rdata%0d", k), rdata[k], 32'h0);
         check($sformatf("reset_irq%0d", k), 32'(irq_o[k]), 32'h0);
      end
      reset = 1'b0;

      // Priming suppresses edges from the reset chain
      idle(4);
      rd_reg(2'd3);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("prime_ec%0d", k), rdata[k], 32'h0);
         check($sformatf("prime_irq%0d", k), 32'(irq_o[k]), 32'h0);
      end
      rd_reg(2'd0);
      check("data0_ff", rdata[0], 32'hFFFF_FFFF);
      check("data1_ff", rdata[1], 32'hFFFF_FFFF);
      check("data2_ff", rdata[2], 32'h0000_00FF);

      // Rising edges, exact latency, write-1-to-clear
      pin[0] = 32'h0;
      idle(4);
      wr_reg(2'd3, 32'hFFFF_FFFF);
      wr_reg(2'd2, 32'h0000_0004);
      pin[0] = 32'h0000_0005;
      step();
      step();
      rd_reg(2'd3);
      check("ec_before_land", rdata[0], 32'h0);
      check("irq_before_land", 32'(irq_o[0]), 32'h0);
      rd_reg(2'd3);
      check("ec_landed", rdata[0], 32'h0000_0005);
      check("irq_set", 32'(irq_o[0]), 32'h1);
      wr_reg(2'd3, 32'h0000_0004);
      check("irq_hold_on_clear", 32'(irq_o[0]), 32'h1);
      rd_reg(2'd3);
      check("ec_after_clear", rdata[0], 32'h0000_0001);
      check("irq_after_clear", 32'(irq_o[0]), 32'h0);

      // Any-edge, set wins over same-cycle clear
      pin[1] = pin[1] ^ 32'h80;
      idle(4);
      rd_reg(2'd3);
      check("any_ec_fall", rdata[1], 32'h0000_0080);
      wr_reg(2'd3, 32'hFFFF_FFFF);
      rd_reg(2'd3);
      check("any_ec_cleared", rdata[1], 32'h0);
      pin[1] = pin[1] ^ 32'h80;
      step();
      step();
      wr_reg(2'd3, 32'h0000_0080);
      rd_reg(2'd3);
      check("set_wins", rdata[1], 32'h0000_0080);

      // Read/write interactions
      chipselect = 1'b1; read = 1'b1; write_n = 1'b0; address = 2'd0; writedata = 32'hDEAD_BEEF;
      step();
      bus_idle();
      check("data_rw_same", rdata[0], 32'h0000_0005);
      rd_reg(2'd1);
      for (int k = 0; k < NI; k++) check($sformatf("dir_zero%0d", k), rdata[k], 32'h0);
      rd_reg(2'd0);
      check("data_unchanged", rdata[0], 32'h0000_0005);
      chipselect = 1'b1; read = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h0000_0300;
      step();
      bus_idle();
      check("mask_prewrite", rdata[0], 32'h0000_0004);
      rd_reg(2'd2);
      check("mask_postwrite", rdata[0], 32'h0000_0300);
      check("mask_w8_trunc", rdata[2], 32'h0);

      // Narrow instance: zero extension and mask truncation
      pin[2] = 32'h0000_00A5;
      idle(3);
      rd_reg(2'd0);
      check("w8_data", rdata[2], 32'h0000_00A5);
      wr_reg(2'd2, 32'hFFFF_FFFF);
      rd_reg(2'd2);
      check("w8_mask", rdata[2], 32'h0000_00FF);
      check("w32_mask", rdata[0], 32'hFFFF_FFFF);
      check("w8_irq", 32'(irq_o[2]), 32'h1);
      rd_reg(2'd3);
      check("w8_fall_ec", rdata[2], 32'h0000_005A);

      // Reset while irq is active
      pin[0] = 32'h0;
      idle(4);
      wr_reg(2'd3, 32'hFFFF_FFFF);
      idle(1);
      pin[0] = 32'h0000_0003;
      idle(4);
      check("pre_reset_irq", 32'(irq_o[0]), 32'h1);
      rd_reg(2'd3);
      check("pre_reset_ec", rdata[0], 32'h0000_0003);
      async_reset("async_rst");
      idle(4);
      rd_reg(2'd3);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("post_rst_ec%0d", k), rdata[k], 32'h0);
         check($sformatf("post_rst_irq%0d", k), 32'(irq_o[k]), 32'h0);
      end
      rd_reg(2'd2);
      check("post_rst_mask0", rdata[0], 32'h0);
      check("post_rst_mask1", rdata[1], 32'h0000_00F0);
      check("post_rst_mask2", rdata[2], 32'h0000_003C);
      rd_reg(2'd0);
      check("post_rst_data0", rdata[0], 32'h0000_0003);

      // Randomized traffic against the model
      for (int it = 0; it < 400; it++) begin
         for (int k = 0; k < NI; k++) begin
            if ($urandom_range(0, 3) == 0) begin
               if ($urandom_range(0, 1) == 0) pin[k] = $urandom();
               else pin[k] = pin[k] ^ (32'h1 << $urandom_range(0, 31));
            end
         end
         chipselect = ($urandom_range(0, 3) != 0);
         read       = $urandom_range(0, 1) == 1;
         write_n    = ($urandom_range(0, 2) != 0);
         address    = 2'($urandom_range(0, 3));
         writedata  = ($urandom_range(0, 1) == 0) ? $urandom() : (32'h1 << $urandom_range(0, 31));
         step();
         if (it == 200) begin
            bus_idle();
            async_reset("rand_rst");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_monitor_dmem_data_in
